uart_tx: RTL and testbench

- Serial UART transmitter, 8N1, LSB first; the transmit counterpart of the board's UART receive path.
- Accepts byte strobes in the sclk domain (50 MHz in the SDRAM/VGA top) into a small FIFO and serialises them onto a single tx line.
- Used to echo or stream bytes, e.g. SDRAM readback and debug status, back to the host.

---
 rtl/uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int BAUD_CNT_END = 5208,
    parameter int FIFO_AW      = 4
) (
    input  logic               sclk,
    input  logic               rst_n,
    input  logic [7:0]         pi_data,
    input  logic               pi_flag,
    output logic               tx,
    output logic               busy,
    output logic               full,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               ovf_flag
);

    localparam int                  c_BAUD_W    = $clog2(BAUD_CNT_END);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(BAUD_CNT_END - 1);
    localparam logic [FIFO_AW:0]    c_DEPTH     = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]          r_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_cnt;
    logic [FIFO_AW:0]    w_cnt_nxt;
    logic                r_full;
    logic                r_ovf;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_head;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [c_BAUD_W-1:0] w_baud_cnt_nxt;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_cnt_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                w_baud_end;

    // ------------------------------------------------------------------------
    // Byte FIFO: a push into a full FIFO is still accepted when a pop frees
    // the slot on the same edge.
    // ------------------------------------------------------------------------
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_push  = pi_flag && ((r_cnt != c_DEPTH) || w_pop);

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + (FIFO_AW+1)'(1);
            2'b01:   w_cnt_nxt = r_cnt - (FIFO_AW+1)'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pi_data;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == c_DEPTH);
            r_ovf  <= pi_flag && !w_push;
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    assign w_baud_end = (r_baud_cnt == c_BAUD_LAST);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;
        w_baud_cnt_nxt = '0;
        if (r_state != S_IDLE && !w_baud_end) begin
            w_baud_cnt_nxt = r_baud_cnt + c_BAUD_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = 3'd0;
                    w_tx_nxt      = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    // Back-to-back frames: next start bit begins with no idle gap.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = S_START;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign tx       = r_tx;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign full     = r_full;
    assign fifo_cnt = r_cnt;
    assign ovf_flag = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Scoreboard bench for uart_tx: frame-level reference model plus
//            a line decoder that checks every transmitted byte.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

    localparam int BAUD  = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * BAUD;

    logic          sclk    = 1'b0;
    logic          rst_n   = 1'b1;
    logic [7:0]    pi_data = 8'h00;
    logic          pi_flag = 1'b0;
    logic          tx;
    logic          busy;
    logic          full;
    logic [AW:0]   fifo_cnt;
    logic          ovf_flag;

    always #5 sclk = ~sclk;

    uart_tx #(
        .BAUD_CNT_END (BAUD),
        .FIFO_AW      (AW)
    ) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .pi_data  (pi_data),
        .pi_flag  (pi_flag),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .fifo_cnt (fifo_cnt),
        .ovf_flag (ovf_flag)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    // Reference model: queue of pending bytes plus cycles left in the
    // frame currently on the line (0 = idle).
    logic [7:0] q_model[$];
    logic [7:0] sb[$];
    int         rem     = 0;
    logic       exp_ovf = 1'b0;

    int         starts[$];
    int         frames_seen = 0;
    logic [7:0] last_byte   = 8'h00;
    int         ovf_seen    = 0;
    int         full_seen   = 0;
    int         cnt_peak    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_state();
        chk("fifo_cnt", 32'(fifo_cnt), q_model.size());
        chk("full", 32'(full), 32'(q_model.size() == DEPTH));
        chk("ovf_flag", 32'(ovf_flag), 32'(exp_ovf));
        chk("busy", 32'(busy), 32'(rem > 0 || q_model.size() > 0));
        if (rem == 0) chk("tx_idle_high", 32'(tx), 1);
        if (ovf_flag === 1'b1) ovf_seen++;
        if (full === 1'b1) full_seen++;
        if (int'(fifo_cnt) > cnt_peak) cnt_peak = int'(fifo_cnt);
    endtask

    // Advance the model by the edge that will sample the inputs just driven.
    task automatic model_edge(input logic f, input logic [7:0] d);
        logic accept;
        if (!rst_n) return;
        if (q_model.size() > 0 && rem <= 1) begin
            void'(q_model.pop_front());
            rem = FRAME;
        end else if (rem > 0) begin
            rem--;
        end
        accept = f && (q_model.size() < DEPTH);
        if (accept) begin
            q_model.push_back(d);
            sb.push_back(d);
        end
        exp_ovf = f && !accept;
    endtask

    task automatic step(input logic f, input logic [7:0] d);
        @(negedge sclk);
        check_state();
        pi_flag = f;
        pi_data = d;
        model_edge(f, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_model.size() > 0 || rem > 0) && n < 5000) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("drain_within_bound", 32'(n < 5000), 1);
        repeat (4) step(1'b0, 8'h00);
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    // Line monitor: decodes each frame at mid-bit and checks it against the
    // scoreboard; a reset during a frame abandons it.
    logic [7:0] mon_b;
    logic       mon_start;
    logic       mon_stop;
    logic       mon_abort;
    int         mon_t0;

    initial begin
        forever begin
            @(negedge sclk);
            if (rst_n && tx === 1'b0) begin
                mon_t0    = cyc;
                mon_abort = 1'b0;
                mon_start = 1'bx;
                mon_stop  = 1'bx;
                mon_b     = 8'hxx;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge sclk);
                    if (!rst_n) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (k == BAUD / 2)
                        mon_start = tx;
                    else if (k > BAUD && k < 9 * BAUD && (k % BAUD) == BAUD / 2)
                        mon_b[k / BAUD - 1] = tx;
                    else if (k == 9 * BAUD + BAUD / 2)
                        mon_stop = tx;
                end
                if (!mon_abort) begin
                    frames_seen++;
                    starts.push_back(mon_t0);
                    last_byte = mon_b;
                    chk("start_bit", 32'(mon_start), 0);
                    chk("stop_bit", 32'(mon_stop), 1);
                    if (sb.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_frame: got byte %02h, expected no frame", mon_b);
                    end else begin
                        chk("rx_byte", 32'(mon_b), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no completion, expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int f0;
        int ns;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("reset_tx", 32'(tx), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_fifo_cnt", 32'(fifo_cnt), 0);
        chk("reset_ovf", 32'(ovf_flag), 0);
        repeat (3) @(negedge sclk);
        rst_n = 1'b1;

        // Single 0x55 from idle
        repeat (3) step(1'b0, 8'h00);
        f0 = frames_seen;
        step(1'b1, 8'h55);
        w = cyc + 1;
        drain();
        chk("t1_frames", frames_seen - f0, 1);
        chk("t1_byte", 32'(last_byte), 32'h55);
        if (starts.size() > 0)
            chk("t1_start_latency", starts[starts.size()-1] - w, 1);

        // Three back-to-back bytes
        f0 = frames_seen;
        cnt_peak = 0;
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hFF);
        drain();
        chk("t2_frames", frames_seen - f0, 3);
        chk("t2_fifo_peak", cnt_peak, 2);
        chk("t2_last_byte", 32'(last_byte), 32'hFF);
        ns = starts.size();
        if (ns >= 3) begin
            chk("t2_gap_1", starts[ns-2] - starts[ns-3], FRAME);
            chk("t2_gap_2", starts[ns-1] - starts[ns-2], FRAME);
        end

        // Overflow, then a write into the full FIFO on the stop-end edge
        f0 = frames_seen;
        ovf_seen  = 0;
        full_seen = 0;
        for (int i = 0; i < 18; i++) step(1'b1, 8'(i));
        repeat (63) step(1'b0, 8'h00);
        step(1'b1, 8'h77);
        step(1'b0, 8'h00);
        chk("t3_cnt_after_full_pop", 32'(fifo_cnt), 16);
        chk("t3_no_ovf_on_full_pop", 32'(ovf_flag), 0);
        drain();
        chk("t3_ovf_pulses", ovf_seen, 1);
        chk("t3_full_seen", 32'(full_seen > 0), 1);
        chk("t3_frames", frames_seen - f0, 18);
        chk("t3_last_byte", 32'(last_byte), 32'h77);

        // Randomised traffic
        repeat (400) step($urandom_range(0, 3) == 0, 8'($urandom));
        drain();

        // Reset in the middle of data bit 3 with 5 bytes queued
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom));
        repeat (30) step(1'b0, 8'h00);
        chk("t5_queued", 32'(fifo_cnt), 5);
        f0 = frames_seen;
        #2 rst_n = 1'b0;
        q_model.delete();
        sb.delete();
        rem     = 0;
        exp_ovf = 1'b0;
        #1;
        chk("t5_tx_on_reset", 32'(tx), 1);
        chk("t5_busy_on_reset", 32'(busy), 0);
        repeat (3) @(negedge sclk);
        rst_n = 1'b1;
        repeat (300) step(1'b0, 8'h00);
        chk("t5_no_residual_frames", frames_seen - f0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
